// File: rtl/uart_cfg_parser.sv
// Parses framed UART write commands into pulse-timing registers, answers ACK/NAK,
// and issues the txdone start strobe for the timing generator.
module uart_cfg_parser #(
    parameter logic [7:0]  HDR0            = 8'hAA,
    parameter logic [7:0]  HDR1            = 8'h55,
    parameter logic [7:0]  ACK_BYTE        = 8'h06,
    parameter logic [7:0]  NAK_BYTE        = 8'h15,
    parameter int unsigned TIMEOUT_CYC     = 100000,
    parameter int unsigned START_PULSE_CYC = 4
) (
    input  logic        sys_clk_100M,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        txdone,
    output logic [63:0] frame_period,
    output logic [31:0] pixel_period,
    output logic [31:0] laser_period,
    output logic [31:0] spad_period,
    output logic [31:0] sig_start_frame,
    output logic [31:0] sig_start_pixel,
    output logic [31:0] sig_start_laser,
    output logic [31:0] sig_start_spad,
    output logic [15:0] duty_cycle_frame,
    output logic [15:0] duty_cycle_pixel,
    output logic [15:0] duty_cycle_laser,
    output logic [15:0] duty_cycle_spad,
    output logic [7:0]  frame_nums,
    output logic [7:0]  pixel_nums,
    output logic [7:0]  laser_nums,
    output logic [7:0]  spad_nums,
    output logic [8:0]  i_cnt_value,
    output logic [7:0]  nak_cnt
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned PW = $clog2(START_PULSE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_H1, S_ID, S_LEN, S_DATA, S_CSUM, S_RESP
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [PW-1:0]   pulse_cnt;
    logic [7:0]      id_q;
    logic [7:0]      len_q;
    logic [7:0]      data_cnt;
    logic [7:0]      xor_q;
    logic [63:0]     shreg;
    logic            commit_pend;
    logic            frame_ok;

    // Register map: an ID is accepted only with its exact payload length.
    function automatic logic len_ok(input logic [7:0] id, input logic [7:0] len);
        case (id)
            8'h00:                      len_ok = (len == 8'd8);
            8'h01, 8'h02, 8'h03:        len_ok = (len == 8'd4);
            8'h10, 8'h11, 8'h12, 8'h13: len_ok = (len == 8'd4);
            8'h20, 8'h21, 8'h22, 8'h23: len_ok = (len == 8'd2);
            8'h30, 8'h31, 8'h32, 8'h33: len_ok = (len == 8'd1);
            8'h40:                      len_ok = (len == 8'd2);
            8'h7F:                      len_ok = (len == 8'd0);
            default:                    len_ok = 1'b0;
        endcase
    endfunction

    always_ff @(posedge sys_clk_100M or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            timer            <= '0;
            pulse_cnt        <= '0;
            id_q             <= '0;
            len_q            <= '0;
            data_cnt         <= '0;
            xor_q            <= '0;
            shreg            <= '0;
            commit_pend      <= 1'b0;
            frame_ok         <= 1'b0;
            tx_data          <= '0;
            tx_valid         <= 1'b0;
            txdone           <= 1'b0;
            frame_period     <= '0;
            pixel_period     <= '0;
            laser_period     <= '0;
            spad_period      <= '0;
            sig_start_frame  <= '0;
            sig_start_pixel  <= '0;
            sig_start_laser  <= '0;
            sig_start_spad   <= '0;
            duty_cycle_frame <= '0;
            duty_cycle_pixel <= '0;
            duty_cycle_laser <= '0;
            duty_cycle_spad  <= '0;
            frame_nums       <= '0;
            pixel_nums       <= '0;
            laser_nums       <= '0;
            spad_nums        <= '0;
            i_cnt_value      <= '0;
            nak_cnt          <= '0;
        end else begin
            // Start strobe countdown; a new START commit below overrides it.
            if (txdone) begin
                if (pulse_cnt == '0) txdone <= 1'b0;
                else                 pulse_cnt <= pulse_cnt - PW'(1);
            end

            // Commit cycle: first cycle of RESP, one clock after the CSUM byte.
            if (commit_pend) begin
                commit_pend <= 1'b0;
                tx_valid    <= 1'b1;
                if (frame_ok) begin
                    tx_data <= ACK_BYTE;
                    case (id_q)
                        8'h00: frame_period     <= shreg;
                        8'h01: pixel_period     <= shreg[31:0];
                        8'h02: laser_period     <= shreg[31:0];
                        8'h03: spad_period      <= shreg[31:0];
                        8'h10: sig_start_frame  <= shreg[31:0];
                        8'h11: sig_start_pixel  <= shreg[31:0];
                        8'h12: sig_start_laser  <= shreg[31:0];
                        8'h13: sig_start_spad   <= shreg[31:0];
                        8'h20: duty_cycle_frame <= shreg[15:0];
                        8'h21: duty_cycle_pixel <= shreg[15:0];
                        8'h22: duty_cycle_laser <= shreg[15:0];
                        8'h23: duty_cycle_spad  <= shreg[15:0];
                        8'h30: frame_nums       <= shreg[7:0];
                        8'h31: pixel_nums       <= shreg[7:0];
                        8'h32: laser_nums       <= shreg[7:0];
                        8'h33: spad_nums        <= shreg[7:0];
                        8'h40: i_cnt_value      <= shreg[8:0];
                        8'h7F: begin
                            txdone    <= 1'b1;
                            pulse_cnt <= PW'(START_PULSE_CYC - 1);
                        end
                        default: ;
                    endcase
                end else begin
                    tx_data <= NAK_BYTE;
                    if (nak_cnt != 8'hFF) nak_cnt <= nak_cnt + 8'd1;
                end
            end

            case (state)
                S_RESP: begin
                    timer <= '0;
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        timer <= '0;
                        case (state)
                            S_IDLE: if (rx_data == HDR0) state <= S_H1;
                            S_H1: begin
                                if (rx_data == HDR1)      state <= S_ID;
                                else if (rx_data != HDR0) state <= S_IDLE;
                            end
                            S_ID: begin
                                id_q  <= rx_data;
                                xor_q <= rx_data;
                                state <= S_LEN;
                            end
                            S_LEN: begin
                                len_q    <= rx_data;
                                xor_q    <= xor_q ^ rx_data;
                                data_cnt <= '0;
                                shreg    <= '0;
                                state    <= (rx_data == 8'd0) ? S_CSUM : S_DATA;
                            end
                            S_DATA: begin
                                shreg    <= {shreg[55:0], rx_data};
                                xor_q    <= xor_q ^ rx_data;
                                data_cnt <= data_cnt + 8'd1;
                                if (data_cnt == len_q - 8'd1) state <= S_CSUM;
                            end
                            S_CSUM: begin
                                frame_ok    <= (rx_data == xor_q) && len_ok(id_q, len_q);
                                commit_pend <= 1'b1;
                                state       <= S_RESP;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (state != S_IDLE) begin
                        // Inter-byte timeout abandons the partial frame silently.
                        if (timer == TW'(TIMEOUT_CYC - 1)) begin
                            timer <= '0;
                            state <= S_IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end else begin
                        timer <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_parser.sv
// Directed bench for uart_cfg_parser: framed writes, START strobe, NAK paths,
// timeout, response back-pressure and asynchronous reset.
module tb_uart_cfg_parser;

    localparam int unsigned TO = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txdone;
    logic [63:0] frame_period;
    logic [31:0] pixel_period, laser_period, spad_period;
    logic [31:0] sig_start_frame, sig_start_pixel, sig_start_laser, sig_start_spad;
    logic [15:0] duty_cycle_frame, duty_cycle_pixel, duty_cycle_laser, duty_cycle_spad;
    logic [7:0]  frame_nums, pixel_nums, laser_nums, spad_nums;
    logic [8:0]  i_cnt_value;
    logic [7:0]  nak_cnt;

    int total  = 0;
    int passed = 0;
    logic [7:0] inj [0:8];

    always #5 clk = ~clk;

    uart_cfg_parser #(.TIMEOUT_CYC(TO)) dut (
        .sys_clk_100M     (clk),
        .reset            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .txdone           (txdone),
        .frame_period     (frame_period),
        .pixel_period     (pixel_period),
        .laser_period     (laser_period),
        .spad_period      (spad_period),
        .sig_start_frame  (sig_start_frame),
        .sig_start_pixel  (sig_start_pixel),
        .sig_start_laser  (sig_start_laser),
        .sig_start_spad   (sig_start_spad),
        .duty_cycle_frame (duty_cycle_frame),
        .duty_cycle_pixel (duty_cycle_pixel),
        .duty_cycle_laser (duty_cycle_laser),
        .duty_cycle_spad  (duty_cycle_spad),
        .frame_nums       (frame_nums),
        .pixel_nums       (pixel_nums),
        .laser_nums       (laser_nums),
        .spad_nums        (spad_nums),
        .i_cnt_value      (i_cnt_value),
        .nak_cnt          (nak_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] len,
                              input logic [63:0] data, input logic [7:0] cs);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(id);
        send_byte(len);
        for (int i = int'(len) - 1; i >= 0; i--) send_byte(data[i*8 +: 8]);
        send_byte(cs);
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (tx_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_byte"}, 64'(tx_data), 64'(exp));
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            check({tag, "_drop"}, 64'(tx_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   highs;
        int   first;
        int   bad;
        logic saw;

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        inj[0] = 8'hAA; inj[1] = 8'h55; inj[2] = 8'h03; inj[3] = 8'h04; inj[4] = 8'h00;
        inj[5] = 8'h00; inj[6] = 8'h00; inj[7] = 8'h99; inj[8] = 8'h9E;
        repeat (3) @(negedge clk);

        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_txdone", 64'(txdone), 64'd0);
        check("rst_nak_cnt", 64'(nak_cnt), 64'd0);
        check("rst_frame_period", frame_period, 64'd0);
        check("rst_periods", {pixel_period, laser_period}, 64'd0);
        check("rst_spad_period", 64'(spad_period), 64'd0);
        check("rst_sig_fp", {sig_start_frame, sig_start_pixel}, 64'd0);
        check("rst_sig_ls", {sig_start_laser, sig_start_spad}, 64'd0);
        check("rst_duty", {duty_cycle_frame, duty_cycle_pixel, duty_cycle_laser, duty_cycle_spad}, 64'd0);
        check("rst_nums", {32'd0, frame_nums, pixel_nums, laser_nums, spad_nums}, 64'd0);
        check("rst_icnt", 64'(i_cnt_value), 64'd0);
        rst_n = 1'b1;

        // Pixel period write
        send_frame(8'h01, 8'd4, 64'h0000_03E8, 8'hEE);
        get_resp("pix", 8'h06);
        check("pix_val", 64'(pixel_period), 64'h3E8);
        check("pix_others", {laser_period, spad_period}, 64'd0);
        check("pix_frame", frame_period, 64'd0);

        // START strobe: low in the CSUM cycle, high 4 clocks from the next
        send_frame(8'h7F, 8'd0, 64'd0, 8'h7F);
        check("start_pre", 64'(txdone), 64'd0);
        highs = 0;
        first = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (txdone) begin
                highs++;
                if (first < 0) first = c;
            end
        end
        check("start_width", 64'(highs), 64'd4);
        check("start_first", 64'(first), 64'd0);
        get_resp("start", 8'h06);

        // Bad checksum
        send_frame(8'h30, 8'd1, 64'h05, 8'h30);
        get_resp("badcs", 8'h15);
        check("badcs_nums", 64'(frame_nums), 64'd0);
        check("badcs_nak", 64'(nak_cnt), 64'd1);

        // Length mismatch
        send_frame(8'h20, 8'd4, 64'h1122_3344, 8'h60);
        get_resp("badlen", 8'h15);
        check("badlen_duty", 64'(duty_cycle_frame), 64'd0);

        // Unmapped ID: no answer until CSUM arrives
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h55); send_byte(8'h01); send_byte(8'hAB);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid) saw = 1'b1;
        end
        check("unmap_early", 64'(saw), 64'd0);
        send_byte(8'hFF);
        get_resp("unmap", 8'h15);
        check("unmap_nak", 64'(nak_cnt), 64'd3);

        // Other widths
        send_frame(8'h21, 8'd2, 64'h1234, 8'h05);
        get_resp("duty", 8'h06);
        check("duty_val", 64'(duty_cycle_pixel), 64'h1234);
        send_frame(8'h32, 8'd1, 64'h07, 8'h34);
        get_resp("nums", 8'h06);
        check("nums_val", 64'(laser_nums), 64'h07);
        send_frame(8'h40, 8'd2, 64'hFFFF, 8'h42);
        get_resp("icnt", 8'h06);
        check("icnt_val", 64'(i_cnt_value), 64'h1FF);

        // Timeout mid-frame, then a full frame_period write
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        saw = 1'b0;
        repeat (TO + 20) begin
            @(negedge clk);
            if (tx_valid) saw = 1'b1;
        end
        check("to_silent", 64'(saw), 64'd0);
        check("to_nak", 64'(nak_cnt), 64'd3);
        send_frame(8'h00, 8'd8, 64'h0123_4567_89AB_CDEF, 8'h08);
        get_resp("fp", 8'h06);
        check("fp_val", frame_period, 64'h0123_4567_89AB_CDEF);

        // Back-pressure: response held while injected bytes are dropped
        send_frame(8'h02, 8'd4, 64'hDEAD_BEEF, 8'h24);
        repeat (2) @(negedge clk);
        check("bp_valid", 64'(tx_valid), 64'd1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h06) bad++;
            if (c < 18 && c % 2 == 0) begin
                rx_data  = inj[c/2];
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        check("bp_stable", 64'(bad), 64'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("bp_drop", 64'(tx_valid), 64'd0);
        check("bp_laser", 64'(laser_period), 64'hDEAD_BEEF);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid) saw = 1'b1;
        end
        check("bp_no_resp", 64'(saw), 64'd0);
        check("bp_spad", 64'(spad_period), 64'd0);
        send_frame(8'h03, 8'd4, 64'h2A, 8'h2D);
        get_resp("spad", 8'h06);
        check("spad_val", 64'(spad_period), 64'h2A);

        // Asynchronous reset mid-DATA
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_frame", frame_period, 64'd0);
        check("ar_periods", {pixel_period, laser_period}, 64'd0);
        check("ar_misc", {duty_cycle_pixel, 7'd0, i_cnt_value, laser_nums, nak_cnt, spad_nums}, 64'd0);
        check("ar_tx", {62'd0, tx_valid, txdone}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Repeated HDR0 before HDR1 still frames correctly
        send_byte(8'hAA);
        send_frame(8'h13, 8'd4, 64'hCAFE_BABE, 8'h27);
        get_resp("sig", 8'h06);
        check("sig_val", 64'(sig_start_spad), 64'hCAFE_BABE);
        check("sig_frame", 64'(sig_start_frame), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
